button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
// PURPOSE
// - Input-side conditioning for board pushbuttons feeding cpu io_in bits.
// - Per button: 2-flop synchroniser, stable-time debounce FSM, one-cycle press/release pulses,
//   sticky press flag cleared by software.
// - Sits between the raw active-low pins (s2, ...) and cpu io_in, in the clk_cpu domain.
// PARAMETERS
// - WIDTH            1       number of independent buttons
// - DEBOUNCE_CYCLES  270000  cycles input must be stable to be accepted (10 ms @ 27 MHz); >= 1
// - localparam CNT_W = $clog2(DEBOUNCE_CYCLES+1)
// PORTS
// - clk            in   1        clock (clk_cpu)
// - rstn           in   1        async active-low reset
// - btn_n          in   WIDTH    raw button pins, active-low, asynchronous
// - clr            in   WIDTH    clear sticky press flag, per bit
// - level          out  WIDTH    debounced state, 1 = pressed
// - press_pulse    out  WIDTH    1-cycle pulse on accepted press
// - release_pulse  out  WIDTH    1-cycle pulse on accepted release
// - press_flag     out  WIDTH    sticky: set by press, cleared by clr
// - press_count    out  8*WIDTH  only with BTN_PRESS_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async assert, deassert at clk edge): sync flops = released, all FSMs IDLE,
//   counters 0, every output 0.
// - Sync: s = ~btn_n through 2 flops; FSM sees only synchronised s.
// - FSM per button, counter cnt[CNT_W-1:0]:
//   - IDLE: s=1 -> PRESS_WAIT, cnt=0.
//   - PRESS_WAIT: s=0 -> IDLE (bounce, discard); s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; else cnt+1.
//   - HELD: s=0 -> RELEASE_WAIT, cnt=0.
//   - RELEASE_WAIT: s=1 -> HELD; s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
// - Outputs are registered:
//   - level = 1 in HELD and RELEASE_WAIT.
//   - press_pulse high for the one cycle after entering HELD from PRESS_WAIT.
//   - release_pulse high for the one cycle after entering IDLE from RELEASE_WAIT.
// - Latency: btn_n falls and stays low -> level and press_pulse rise on clk edge
//   DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES count + 1 output reg). Release is symmetric.
// - Bounce shorter than DEBOUNCE_CYCLES: no level change, no pulses.
// - The counter never wraps; it is compared with DEBOUNCE_CYCLES-1 before incrementing.
// - press_flag:
//   - set on press_pulse; cleared on clr.
//   - set and clr in the same cycle -> stays/becomes 1 (set wins, no lost press).
//   - clr while 0: no effect.
// - Button held through reset: after reset deassert it is treated as a fresh press
//   (press_pulse after the normal latency).
// - Reset mid-debounce: counter and FSM discarded, no pulse.
// - Buttons are fully independent; simultaneous events on different bits all reported
//   in the same cycle.
// CONFIGURATION
// - BTN_PRESS_CNT_EN defined:
//   - press_count[8*i+7:8*i] increments on each press_pulse[i], saturating at 255.
//   - clr[i] also zeroes it; clr wins over increment in the same cycle.
//   - Reset value 0.
// - BTN_PRESS_CNT_EN undefined: press_count port absent; no counter logic.
// TESTING (bench: WIDTH=2, DEBOUNCE_CYCLES=4)
// - Reset with btn_n=2'b11 -> all outputs 0.
//   Release rstn, hold 20 cycles -> outputs stay 0.
// - Clean press, btn_n[0] 1->0 held -> level[0]=1 and press_pulse[0]=1 on edge 7.
//   press_pulse[0] is 0 on edge 8; press_flag[0]=1.
// - Bounce: btn_n[0] low 3 cycles, high 1, low 2, high -> level[0], both pulses and press_flag stay 0.
// - Release after press: btn_n[0] 0->1 held -> level[0]=0 and release_pulse[0]=1 on edge 7,
//   for one cycle.
// - Flag race: clr[0]=1 in the same cycle as press_pulse[0] -> press_flag[0]=1.
//   clr[0]=1 next cycle -> press_flag[0]=0.
// - Both buttons pressed on the same edge -> press_pulse=2'b11 in the same cycle.
//   With BTN_PRESS_CNT_EN: 300 presses on btn 1 -> press_count[15:8]=255.

Source files
------------

// File: rtl/button_debouncer.sv
// Pushbutton conditioner: 2-flop sync, stable-time debounce FSM, press/release pulses, sticky flag.
// Optional per-button saturating press counter when BTN_PRESS_CNT_EN is defined.

module button_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_n,
  input  logic       clr,
  output logic       level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       press_flag
`ifdef BTN_PRESS_CNT_EN
  ,
  output logic [7:0] press_count
`endif
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1, s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= ~btn_n;
      s     <= sync1;
    end
  end

  // Output registers are updated on the same edge as the state change,
  // so level/pulses appear exactly when the FSM accepts the new state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: if (s) begin
          state <= PRESS_WAIT;
          cnt   <= '0;
        end
        PRESS_WAIT: begin
          if (!s) state <= IDLE;
          else if (cnt == CNT_LAST) begin
            state       <= HELD;
            level       <= 1'b1;
            press_pulse <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        HELD: if (!s) begin
          state <= RELEASE_WAIT;
          cnt   <= '0;
        end
        RELEASE_WAIT: begin
          if (s) state <= HELD;
          else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Set wins over clear so a press coinciding with a software clear is not lost.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) press_flag <= 1'b0;
    else       press_flag <= press_pulse | (press_flag & ~clr);
  end

`ifdef BTN_PRESS_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                  press_count <= '0;
    else if (clr)                               press_count <= '0;
    else if (press_pulse && press_count != 8'hFF) press_count <= press_count + 8'd1;
  end
`endif
endmodule

module button_debouncer #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     btn_n,
  input  logic [WIDTH-1:0]     clr,
  output logic [WIDTH-1:0]     level,
  output logic [WIDTH-1:0]     press_pulse,
  output logic [WIDTH-1:0]     release_pulse,
  output logic [WIDTH-1:0]     press_flag
`ifdef BTN_PRESS_CNT_EN
  ,
  output logic [8*WIDTH-1:0]   press_count
`endif
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    button_debouncer_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk          (clk),
      .rstn         (rstn),
      .btn_n        (btn_n[i]),
      .clr          (clr[i]),
      .level        (level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .press_flag   (press_flag[i])
`ifdef BTN_PRESS_CNT_EN
      ,
      .press_count  (press_count[8*i +: 8])
`endif
    );
  end
endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (WIDTH=2, DEBOUNCE_CYCLES=4) with a run-length reference model.
// Checks press_count too when BTN_PRESS_CNT_EN is defined.
module tb_button_debouncer;
  localparam int W = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] btn_n, clr;
  logic [W-1:0] level, press_pulse, release_pulse, press_flag;
  logic [15:0]  cnt_act;
`ifdef BTN_PRESS_CNT_EN
  logic [8*W-1:0] press_count;
  assign cnt_act = press_count;
`else
  assign cnt_act = '0;
`endif

  button_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .btn_n        (btn_n),
    .clr          (clr),
    .level        (level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_flag   (press_flag)
`ifdef BTN_PRESS_CNT_EN
    ,
    .press_count  (press_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] level, pp, rp, flag;
    logic [15:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: a button's accepted level flips once the synchronised input has
  // disagreed with it on D+1 consecutive sampled edges; any agreement restarts the run.
  bit m_s1[W], m_s2[W], m_lvl[W], m_pp[W], m_rp[W], m_flag[W];
  int m_run[W], m_cnt[W];

  initial forever begin
    exp_t e;
    @(posedge clk);
    for (int i = 0; i < W; i++) begin
      if (!rstn) begin
        m_s1[i] = 0; m_s2[i] = 0; m_lvl[i] = 0; m_pp[i] = 0; m_rp[i] = 0;
        m_flag[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
      end else begin
        bit su;
        su = m_s2[i];
        m_s2[i] = m_s1[i];
        m_s1[i] = ~btn_n[i];
        if (clr[i]) m_cnt[i] = 0;
        else if (m_pp[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
        m_flag[i] = m_pp[i] | (m_flag[i] & ~clr[i]);
        m_pp[i] = 0;
        m_rp[i] = 0;
        if (su != m_lvl[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D + 1) begin
            m_lvl[i] = su;
            m_pp[i]  = su;
            m_rp[i]  = !su;
            m_run[i] = 0;
          end
        end else m_run[i] = 0;
      end
      e.level[i] = m_lvl[i];
      e.pp[i]    = m_pp[i];
      e.rp[i]    = m_rp[i];
      e.flag[i]  = m_flag[i];
      e.cnt[8*i +: 8] = 8'(m_cnt[i]);
    end
    q.push_back(e);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a new output set, compared on the falling edge.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!rstn) e = '0;
      chk("level",         16'(level),         16'(e.level));
      chk("press_pulse",   16'(press_pulse),   16'(e.pp));
      chk("release_pulse", 16'(release_pulse), 16'(e.rp));
      chk("press_flag",    16'(press_flag),    16'(e.flag));
`ifdef BTN_PRESS_CNT_EN
      chk("press_count",   cnt_act,            e.cnt);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rstn = 1'b0; btn_n = 2'b11; clr = 2'b00;
    step(3);
    rstn = 1'b1; step(20);
    // clean press then release on button 0
    btn_n = 2'b10; step(10);
    btn_n = 2'b11; step(10);
    // bounce shorter than the debounce window
    btn_n = 2'b10; step(3); btn_n = 2'b11; step(1);
    btn_n = 2'b10; step(2); btn_n = 2'b11; step(10);
    // clr coincident with press_pulse, then clr on the following cycle
    btn_n = 2'b10; step(7);
    clr = 2'b01; step(1);
    clr = 2'b01; step(1);
    clr = 2'b00; step(5);
    btn_n = 2'b11; step(10);
    // both buttons on the same edge
    btn_n = 2'b00; step(10);
    btn_n = 2'b11; step(10);
    // held through reset, then reset mid-debounce
    btn_n = 2'b10; step(10);
    rstn = 1'b0; step(2); rstn = 1'b1; step(10);
    btn_n = 2'b11; step(10);
    btn_n = 2'b10; step(3);
    rstn = 1'b0; step(1); btn_n = 2'b11; rstn = 1'b1; step(10);
    // many presses on button 1 to reach counter saturation
    repeat (300) begin
      btn_n = 2'b01; step(7);
      btn_n = 2'b11; step(7);
    end
    // randomized traffic with occasional clears and resets
    repeat (3000) begin
      btn_n = W'($urandom);
      clr   = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      if ($urandom_range(0, 199) == 0) begin
        rstn = 1'b0; step($urandom_range(1, 3)); rstn = 1'b1;
      end
      step($urandom_range(1, 8));
    end
    clr = '0; btn_n = 2'b11;
    step(3);
    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
